exp_operand_loader: RTL and testbench

//  Host-side initiator for the exponentiation core: receives operands x, modulus, exponent,

---
 rtl/exp_loader_pkg.sv | 39 +++
 rtl/exp_result_serializer.sv | 41 ++++
 rtl/exp_operand_loader.sv | 158 +++++++++++++++
 tb/tb_exp_operand_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_loader_pkg.sv
// rtl/exp_loader_pkg.sv - shared sizes, field offsets and FSM encoding for the operand loader
// Purpose: one place for the stream/operand geometry used by the loader and its serializer.
//   WORD_W / OP_W / EXP_W : stream word, operand and exponent widths
//   WORDS_*               : words per field and per full input transfer
//   *_BASE                : first word index of each field in the input stream
package exp_loader_pkg;

  localparam int WORD_W      = 32;
  localparam int OP_W        = 512;
  localparam int EXP_W       = 1024;

  localparam int WORDS_OP    = OP_W / WORD_W;
  localparam int WORDS_EXP   = EXP_W / WORD_W;
  localparam int TOTAL_WORDS = 4 * WORDS_OP + WORDS_EXP;
  localparam int CNT_W       = $clog2(TOTAL_WORDS);

  // Input stream order: x, modulus, exponent, Rmodm, Rsquaredmodm.
  localparam int X_BASE      = 0;
  localparam int M_BASE      = X_BASE + WORDS_OP;
  localparam int E_BASE      = M_BASE + WORDS_OP;
  localparam int RM_BASE     = E_BASE + WORDS_EXP;
  localparam int R2_BASE     = RM_BASE + WORDS_OP;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD
  } state_e;

  typedef enum logic [2:0] {
    F_X,
    F_M,
    F_E,
    F_RM,
    F_R2
  } field_e;

endpackage

// File: rtl/exp_result_serializer.sv
// rtl/exp_result_serializer.sv - parallel-load result register shifted out one word per transfer
// Purpose: holds A_result and presents its least-significant unsent word.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   load_i, data_i   capture a full OP_W result
//   valid_i          output word is being offered (driven by the loader FSM)
//   ready_i          sink accepts the word
//   valid_o, data_o  offered word and its valid
//   xfer_o           a word moved this cycle
module exp_result_serializer
  import exp_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_i,
  input  logic [OP_W-1:0]   data_i,
  input  logic              valid_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic              xfer_o
);

  logic [OP_W-1:0] shift_q;

  assign xfer_o  = valid_i & ready_i;
  assign valid_o = valid_i;
  assign data_o  = shift_q[WORD_W-1:0];

  // The word only advances on a completed handshake, so data_o is stable under backpressure.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
    end else if (load_i) begin
      shift_q <= data_i;
    end else if (xfer_o) begin
      shift_q <= shift_q >> WORD_W;
    end
  end

endmodule

// File: rtl/exp_operand_loader.sv
// rtl/exp_operand_loader.sv - streams operands into the exponentiation core and its result back out
// Purpose: collects 96 input words into x/modulus/exponent/Rmodm/Rsquaredmodm, pulses exp_start,
//   waits for exp_done, then emits the 16-word result least-significant word first.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   s_data/s_valid/s_ready      input word stream (accepted only while loading)
//   m_data/m_valid/m_ready      result word stream
//   busy                        high from start pulse until the last result word leaves
//   exp_start/exp_done          core handshake
//   exp_result                  core result, captured on exp_done while waiting
//   x, modulus, exponent, Rmodm, Rsquaredmodm   operand registers to the core
module exp_operand_loader
  import exp_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              exp_start,
  input  logic              exp_done,
  input  logic [OP_W-1:0]   exp_result,
  output logic [OP_W-1:0]   x,
  output logic [OP_W-1:0]   modulus,
  output logic [EXP_W-1:0]  exponent,
  output logic [OP_W-1:0]   Rmodm,
  output logic [OP_W-1:0]   Rsquaredmodm
);

  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(TOTAL_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(WORDS_OP - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_ready_q, s_ready_d;
  logic [OP_W-1:0]   x_q, m_q, rm_q, r2_q;
  logic [EXP_W-1:0]  e_q;

  logic              s_xfer;
  logic              m_xfer;
  logic              ld_result;
  field_e            field;
  logic [CNT_W-1:0]  off;

  assign s_ready      = s_ready_q;
  assign s_xfer       = s_valid & s_ready_q;
  assign exp_start    = (state_q == ST_START);
  assign busy         = (state_q != ST_LOAD);
  assign x            = x_q;
  assign modulus      = m_q;
  assign exponent     = e_q;
  assign Rmodm        = rm_q;
  assign Rsquaredmodm = r2_q;

  exp_result_serializer u_ser (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (ld_result),
    .data_i  (exp_result),
    .valid_i (state_q == ST_UNLOAD),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .xfer_o  (m_xfer)
  );

  // Map the stream word index onto a field and a word offset inside that field.
  always_comb begin
    field = F_X;
    off   = cnt_q;
    if (cnt_q >= CNT_W'(R2_BASE)) begin
      field = F_R2;
      off   = cnt_q - CNT_W'(R2_BASE);
    end else if (cnt_q >= CNT_W'(RM_BASE)) begin
      field = F_RM;
      off   = cnt_q - CNT_W'(RM_BASE);
    end else if (cnt_q >= CNT_W'(E_BASE)) begin
      field = F_E;
      off   = cnt_q - CNT_W'(E_BASE);
    end else if (cnt_q >= CNT_W'(M_BASE)) begin
      field = F_M;
      off   = cnt_q - CNT_W'(M_BASE);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_result = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (s_xfer) begin
          if (cnt_q == LAST_IN) begin
            state_d = ST_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (exp_done) begin
          ld_result = 1'b1;
          state_d   = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (m_xfer) begin
          if (cnt_q == LAST_OUT) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // s_ready is registered from the next state so it falls on the edge that takes word 95.
    s_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q  <= '0;
      m_q  <= '0;
      e_q  <= '0;
      rm_q <= '0;
      r2_q <= '0;
    end else if (s_xfer) begin
      unique case (field)
        F_X:     x_q[int'(off)*WORD_W +: WORD_W]  <= s_data;
        F_M:     m_q[int'(off)*WORD_W +: WORD_W]  <= s_data;
        F_E:     e_q[int'(off)*WORD_W +: WORD_W]  <= s_data;
        F_RM:    rm_q[int'(off)*WORD_W +: WORD_W] <= s_data;
        default: r2_q[int'(off)*WORD_W +: WORD_W] <= s_data;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_operand_loader.sv
// tb/tb_exp_operand_loader.sv - self-checking bench for exp_operand_loader
module tb_exp_operand_loader;

  logic          clk;
  logic          resetn;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          exp_start;
  logic          exp_done;
  logic [511:0]  exp_result;
  logic [511:0]  x;
  logic [511:0]  modulus;
  logic [1023:0] exponent;
  logic [511:0]  Rmodm;
  logic [511:0]  Rsquaredmodm;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  exp_operand_loader dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .exp_start    (exp_start),
    .exp_done     (exp_done),
    .exp_result   (exp_result),
    .x            (x),
    .modulus      (modulus),
    .exponent     (exponent),
    .Rmodm        (Rmodm),
    .Rsquaredmodm (Rsquaredmodm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] rand_op();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [1023:0] rand_exp();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_word(input logic [31:0] w);
    int budget = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic load_all(input logic [511:0] vx, input logic [511:0] vm,
                          input logic [1023:0] ve, input logic [511:0] vrm,
                          input logic [511:0] vr2, input bit gaps, input bit spurious);
    logic [31:0] w [96];
    for (int i = 0; i < 16; i++) begin
      w[i]      = vx[i*32 +: 32];
      w[16 + i] = vm[i*32 +: 32];
      w[64 + i] = vrm[i*32 +: 32];
      w[80 + i] = vr2[i*32 +: 32];
    end
    for (int i = 0; i < 32; i++) w[32 + i] = ve[i*32 +: 32];
    for (int i = 0; i < 96; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      if (spurious) begin
        exp_done   = 1'($urandom_range(0, 1));
        exp_result = rand_op();
      end
      send_word(w[i]);
      if (i < 95) begin
        checks++;
        if (busy !== 1'b0 || exp_start !== 1'b0) begin
          errors++;
          $display("FAIL load_idle word %0d: busy=%0b exp_start=%0b required 0 0", i, busy, exp_start);
        end
      end
    end
    exp_done = 1'b0;
    checks++;
    if (exp_start !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: exp_start=%0b s_ready=%0b required 1 0", exp_start, s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_start !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_width: exp_start=%0b busy=%0b s_ready=%0b required 0 1 0", exp_start, busy, s_ready);
    end
    checks++;
    if (x !== vx || modulus !== vm || exponent !== ve || Rmodm !== vrm || Rsquaredmodm !== vr2) begin
      errors++;
      $display("FAIL operands: x=%0h m=%0h Rmodm=%0h R2=%0h required x=%0h m=%0h Rmodm=%0h R2=%0h",
               x[63:0], modulus[63:0], Rmodm[63:0], Rsquaredmodm[63:0],
               vx[63:0], vm[63:0], vrm[63:0], vr2[63:0]);
    end
  endtask

  // Entered in WAIT; plays the core, then drains the result through the scoreboard.
  task automatic run_core(input logic [511:0] res, input int wait_cycles,
                          input bit rand_ready, input bit spurious);
    int n = 0;
    int budget = 0;
    logic [31:0] prev = '0;
    logic prev_stall = 1'b0;
    logic [31:0] exp_w;
    repeat (wait_cycles) begin
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_quiet: m_valid=%0b s_ready=%0b required 0 0", m_valid, s_ready);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) sb_q.push_back(res[i*32 +: 32]);
    exp_done   = 1'b1;
    exp_result = res;
    @(posedge clk); #1;
    exp_done   = 1'b0;
    exp_result = '0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== res[31:0]) begin
      errors++;
      $display("FAIL done_latency: m_valid=%0b m_data=%08h required 1 %08h", m_valid, m_data, res[31:0]);
    end
    while (n < 16 && budget < 2000) begin
      if (m_valid && prev_stall) begin
        checks++;
        if (m_data !== prev) begin
          errors++;
          $display("FAIL hold_stable: m_data=%08h required %08h", m_data, prev);
        end
      end
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (spurious) begin
        exp_done   = 1'($urandom_range(0, 1));
        exp_result = rand_op();
      end
      if (m_valid && m_ready) begin
        exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (m_data !== exp_w) begin
          errors++;
          $display("FAIL result_word %0d: m_data=%08h required %08h", n, m_data, exp_w);
        end
        n++;
      end
      prev_stall = m_valid && !m_ready;
      prev       = m_data;
      @(posedge clk); #1;
      budget++;
    end
    exp_done = 1'b0;
    m_ready  = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL unload_timeout: words=%0d required 16", n);
    end
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL unload_end: m_valid=%0b s_ready=%0b busy=%0b pending=%0d required 0 1 0 0",
               m_valid, s_ready, busy, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || exp_start !== 1'b0 ||
        m_data !== '0 || x !== '0 || modulus !== '0 || exponent !== '0 ||
        Rmodm !== '0 || Rsquaredmodm !== '0) begin
      errors++;
      $display("FAIL %s: s_ready=%0b m_valid=%0b busy=%0b exp_start=%0b m_data=%08h x=%0h e=%0h required all 0",
               tag, s_ready, m_valid, busy, exp_start, m_data, x[63:0], exponent[63:0]);
    end
  endtask

  task automatic test_reset();
    logic [511:0] vx;
    vx = rand_op();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_initial");
    resetn = 1'b1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: s_ready=%0b required 0", s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: s_ready=%0b required 1", s_ready);
    end
    for (int i = 0; i < 40; i++) send_word((i < 16) ? vx[i*32 +: 32] : $urandom());
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset_midload");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_vector();
    logic [511:0] vx, vm, vrm, vr2, res;
    logic [1023:0] ve;
    vx  = rand_op(); vx[511:496]  = 16'h87b2; vx[15:0]  = 16'h9589;
    vm  = rand_op(); vm[511:496]  = 16'hd97a; vm[15:0]  = 16'h5885;
    vrm = rand_op(); vrm[511:496] = 16'h2685; vrm[15:0] = 16'ha77b;
    vr2 = rand_op(); vr2[511:496] = 16'h733f; vr2[15:0] = 16'h57ad;
    ve  = 1024'haf;
    res = rand_op(); res[31:0] = 32'hf7400189; res[511:480] = 32'hbdb2a4a4;
    load_all(vx, vm, ve, vrm, vr2, 1'b0, 1'b0);
    run_core(res, 3, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    load_all(rand_op(), rand_op(), rand_exp(), rand_op(), rand_op(), 1'b1, 1'b0);
    run_core(rand_op(), 5, 1'b1, 1'b0);
  endtask

  task automatic test_spurious_done();
    load_all(rand_op(), rand_op(), rand_exp(), rand_op(), rand_op(), 1'b1, 1'b1);
    run_core(rand_op(), 2, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      load_all(rand_op(), rand_op(), rand_exp(), rand_op(), rand_op(), 1'b0, 1'b0);
      run_core(rand_op(), r, 1'b1, 1'b0);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    s_data     = '0;
    s_valid    = 1'b0;
    m_ready    = 1'b0;
    exp_done   = 1'b0;
    exp_result = '0;
    test_reset();
    test_load_vector();
    test_backpressure();
    test_spurious_done();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
